// File: rtl/targeting_pkg.sv
// Shared constants, state encoding and sensor pattern helpers for the targeting sequencer.
package targeting_pkg;

  localparam int SENSOR_W_DEF     = 3;
  localparam int CALIB_CYCLES_DEF = 2;
  localparam int WINDOW_LEN_DEF   = 16;
  localparam int HITS_REQ_DEF     = 2;
  localparam int FIRE_LEN_DEF     = 1;
  localparam int COOLDOWN_DEF     = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CALIB     = 3'd1;
  localparam state_t ST_GATE_LEFT = 3'd2;
  localparam state_t ST_WINDOW    = 3'd3;
  localparam state_t ST_FIRE      = 3'd4;
  localparam state_t ST_COOLDOWN  = 3'd5;

  // Patterns are built 32 bits wide; callers truncate to their bus width (w < 32).
  function automatic logic [31:0] cal_pat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] gl_pat(input int unsigned w);
    return (w > 32'd0) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] gc_pat(input int unsigned w);
    return 32'd1 << (w / 32'd2);
  endfunction

  function automatic logic [31:0] hit_pat(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic logic [31:0] abort_pat(input int unsigned w);
    return hit_pat(w) | gl_pat(w);
  endfunction

endpackage

// File: rtl/targeting_window_ctr.sv
// Window cycle and hit counters; flags the last window cycle and when one more hit completes the count.
module targeting_window_ctr #(
  parameter int WINDOW_LEN = 16,
  parameter int HITS_REQ   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic start_i,
  input  logic step_i,
  input  logic hit_i,
  output logic last_cycle_o,
  output logic hits_done_o
);

  localparam int CYC_W = $clog2(WINDOW_LEN + 1);
  localparam int HIT_W = $clog2(HITS_REQ + 1);

  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [HIT_W-1:0] hits_q, hits_d;

  // Next-state for both counters; both saturate rather than wrap.
  always_comb begin
    cycle_d = cycle_q;
    hits_d  = hits_q;
    if (clr_i) begin
      cycle_d = CYC_W'(0);
      hits_d  = HIT_W'(0);
    end else if (start_i) begin
      cycle_d = CYC_W'(1);
      hits_d  = HIT_W'(0);
    end else if (step_i) begin
      if (hit_i && (hits_q < HIT_W'(HITS_REQ))) begin
        hits_d = hits_q + HIT_W'(1);
      end else begin
        hits_d = hits_q;
      end
      if (cycle_q < CYC_W'(WINDOW_LEN)) begin
        cycle_d = cycle_q + CYC_W'(1);
      end else begin
        cycle_d = cycle_q;
      end
    end else begin
      cycle_d = cycle_q;
      hits_d  = hits_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= CYC_W'(0);
      hits_q  <= HIT_W'(0);
    end else begin
      cycle_q <= cycle_d;
      hits_q  <= hits_d;
    end
  end

  assign last_cycle_o = (cycle_q == CYC_W'(WINDOW_LEN));
  assign hits_done_o  = (hits_q == HIT_W'(HITS_REQ - 1));

endmodule

// File: rtl/targeting_controller.sv
// Proton targeting sequencer: calibration/gate detection, hit window, fire pulse, cooldown and shot counter.
module targeting_controller import targeting_pkg::*; #(
  parameter int SENSOR_W     = SENSOR_W_DEF,
  parameter int CALIB_CYCLES = CALIB_CYCLES_DEF,
  parameter int WINDOW_LEN   = WINDOW_LEN_DEF,
  parameter int HITS_REQ     = HITS_REQ_DEF,
  parameter int FIRE_LEN     = FIRE_LEN_DEF,
  parameter int COOLDOWN     = COOLDOWN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm_en,
  input  logic [SENSOR_W-1:0] sensor_in,
  output logic                proton_fire,
  output logic                abort_o,
  output logic                timeout_o,
  output logic                busy,
  output logic [2:0]          state_o,
  output logic [7:0]          fire_count
);

  localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
  localparam int FIRE_W = $clog2(FIRE_LEN + 1);
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [SENSOR_W-1:0] PAT_CAL   = SENSOR_W'(cal_pat(SENSOR_W));
  localparam logic [SENSOR_W-1:0] PAT_GL    = SENSOR_W'(gl_pat(SENSOR_W));
  localparam logic [SENSOR_W-1:0] PAT_GC    = SENSOR_W'(gc_pat(SENSOR_W));
  localparam logic [SENSOR_W-1:0] PAT_HIT   = SENSOR_W'(hit_pat(SENSOR_W));
  localparam logic [SENSOR_W-1:0] PAT_ABORT = SENSOR_W'(abort_pat(SENSOR_W));

  state_t            state_q, state_d;
  logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
  logic [FIRE_W-1:0] fire_cnt_q, fire_cnt_d;
  logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
  logic              fire_q, fire_d;
  logic              abort_q, abort_d;
  logic              timeout_q, timeout_d;
  logic              busy_q;
  logic [7:0]        fire_count_q, fire_count_d;

  logic is_cal_s, is_gl_s, is_gc_s, is_hit_s, is_abort_s;
  logic win_clr_s, win_start_s, win_step_s;
  logic last_cycle_s, hits_done_s;

  assign is_cal_s   = (sensor_in == PAT_CAL);
  assign is_gl_s    = (sensor_in == PAT_GL);
  assign is_gc_s    = (sensor_in == PAT_GC);
  assign is_hit_s   = (sensor_in == PAT_HIT);
  assign is_abort_s = (sensor_in == PAT_ABORT);

  targeting_window_ctr #(
    .WINDOW_LEN (WINDOW_LEN),
    .HITS_REQ   (HITS_REQ)
  ) u_window_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (win_clr_s),
    .start_i      (win_start_s),
    .step_i       (win_step_s),
    .hit_i        (is_hit_s),
    .last_cycle_o (last_cycle_s),
    .hits_done_o  (hits_done_s)
  );

  // Sequencer next-state; disarm is only honoured before the fire commitment.
  always_comb begin
    state_d      = state_q;
    cal_cnt_d    = cal_cnt_q;
    fire_cnt_d   = fire_cnt_q;
    cd_cnt_d     = cd_cnt_q;
    fire_d       = fire_q;
    abort_d      = 1'b0;
    timeout_d    = 1'b0;
    fire_count_d = fire_count_q;
    win_clr_s    = 1'b0;
    win_start_s  = 1'b0;
    win_step_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_en && is_cal_s) begin
          state_d   = ST_CALIB;
          cal_cnt_d = CAL_W'(1);
        end else begin
          cal_cnt_d = CAL_W'(0);
        end
      end
      ST_CALIB: begin
        if (!arm_en) begin
          state_d   = ST_IDLE;
          cal_cnt_d = CAL_W'(0);
        end else if (cal_cnt_q < CAL_W'(CALIB_CYCLES)) begin
          if (is_cal_s) begin
            cal_cnt_d = cal_cnt_q + CAL_W'(1);
          end else begin
            state_d   = ST_IDLE;
            cal_cnt_d = CAL_W'(0);
          end
        end else begin
          state_d   = is_gl_s ? ST_GATE_LEFT : ST_IDLE;
          cal_cnt_d = CAL_W'(0);
        end
      end
      ST_GATE_LEFT: begin
        if (arm_en && is_gc_s) begin
          state_d     = ST_WINDOW;
          win_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WINDOW: begin
        if (!arm_en) begin
          state_d   = ST_IDLE;
          win_clr_s = 1'b1;
        end else if (is_abort_s) begin
          state_d   = ST_IDLE;
          abort_d   = 1'b1;
          win_clr_s = 1'b1;
        end else if (is_hit_s && hits_done_s) begin
          state_d      = ST_FIRE;
          fire_d       = 1'b1;
          fire_cnt_d   = FIRE_W'(1);
          fire_count_d = (fire_count_q == 8'hFF) ? 8'hFF : fire_count_q + 8'd1;
          win_clr_s    = 1'b1;
        end else if (last_cycle_s) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          win_clr_s = 1'b1;
        end else begin
          win_step_s = 1'b1;
        end
      end
      ST_FIRE: begin
        if (fire_cnt_q == FIRE_W'(FIRE_LEN)) begin
          fire_d     = 1'b0;
          fire_cnt_d = FIRE_W'(0);
          if (COOLDOWN == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_COOLDOWN;
            cd_cnt_d = CD_W'(1);
          end
        end else begin
          fire_cnt_d = fire_cnt_q + FIRE_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q == CD_W'(COOLDOWN)) begin
          state_d  = ST_IDLE;
          cd_cnt_d = CD_W'(0);
        end else begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cal_cnt_d  = CAL_W'(0);
        fire_cnt_d = FIRE_W'(0);
        cd_cnt_d   = CD_W'(0);
        fire_d     = 1'b0;
        win_clr_s  = 1'b1;
      end
    endcase
  end

  // State, timers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cal_cnt_q    <= CAL_W'(0);
      fire_cnt_q   <= FIRE_W'(0);
      cd_cnt_q     <= CD_W'(0);
      fire_q       <= 1'b0;
      abort_q      <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      fire_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cal_cnt_q    <= cal_cnt_d;
      fire_cnt_q   <= fire_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      fire_q       <= fire_d;
      abort_q      <= abort_d;
      timeout_q    <= timeout_d;
      busy_q       <= (state_d != ST_IDLE);
      fire_count_q <= fire_count_d;
    end
  end

  assign proton_fire = fire_q;
  assign abort_o     = abort_q;
  assign timeout_o   = timeout_q;
  assign busy        = busy_q;
  assign state_o     = state_q;
  assign fire_count  = fire_count_q;

endmodule

// File: tb/tb_targeting_controller.sv
// Scoreboard bench: default-parameter instance A and a wide/long-pulse instance B.
module tb_targeting_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_na, arm_a;
  logic [2:0] sens_a;
  logic       fire_a, abort_a, timeout_a, busy_a;
  logic [2:0] st_a;
  logic [7:0] cnt_a;

  logic       rst_nb, arm_b;
  logic [4:0] sens_b;
  logic       fire_b, abort_b, timeout_b, busy_b;
  logic [2:0] st_b;
  logic [7:0] cnt_b;

  targeting_controller dut_a (
    .clk(clk), .rst_n(rst_na), .arm_en(arm_a), .sensor_in(sens_a),
    .proton_fire(fire_a), .abort_o(abort_a), .timeout_o(timeout_a),
    .busy(busy_a), .state_o(st_a), .fire_count(cnt_a)
  );

  targeting_controller #(
    .SENSOR_W(5), .CALIB_CYCLES(3), .WINDOW_LEN(16), .HITS_REQ(3), .FIRE_LEN(4), .COOLDOWN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_nb), .arm_en(arm_b), .sensor_in(sens_b),
    .proton_fire(fire_b), .abort_o(abort_b), .timeout_o(timeout_b),
    .busy(busy_b), .state_o(st_b), .fire_count(cnt_b)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       fire;
    logic       ab;
    logic       to;
  } exp_t;

  exp_t  q_a[$];
  exp_t  q_b[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_cnt_a = 0;
  int    exp_cnt_b = 0;
  string phase = "reset";

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // One cycle on instance A: push expectation, clock, pop and compare.
  task automatic step_a(input logic arm, input logic [2:0] s, input logic [2:0] st,
                        input logic f, input logic ab, input logic to);
    exp_t e;
    arm_a  = arm;
    sens_a = s;
    e.st = st; e.fire = f; e.ab = ab; e.to = to;
    q_a.push_back(e);
    @(posedge clk);
    #1;
    e = q_a.pop_front();
    check_val("a_state", 32'(st_a), 32'(e.st));
    check_val("a_fire", 32'(fire_a), 32'(e.fire));
    check_val("a_abort", 32'(abort_a), 32'(e.ab));
    check_val("a_timeout", 32'(timeout_a), 32'(e.to));
    check_val("a_busy", 32'(busy_a), 32'(e.st != 3'd0));
  endtask

  task automatic step_b(input logic [4:0] s, input logic [2:0] st, input logic f);
    exp_t e;
    arm_b  = 1'b1;
    sens_b = s;
    e.st = st; e.fire = f; e.ab = 1'b0; e.to = 1'b0;
    q_b.push_back(e);
    @(posedge clk);
    #1;
    e = q_b.pop_front();
    check_val("b_state", 32'(st_b), 32'(e.st));
    check_val("b_fire", 32'(fire_b), 32'(e.fire));
    check_val("b_abort", 32'(abort_b), 32'(e.ab));
    check_val("b_timeout", 32'(timeout_b), 32'(e.to));
  endtask

  task automatic prefix_a();
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b001, 3'd2, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b010, 3'd3, 1'b0, 1'b0, 1'b0);
  endtask

  // From FIRE: one edge into COOLDOWN, 7 more in COOLDOWN, then back to IDLE.
  task automatic cooldown_a(input logic arm, input logic [2:0] s);
    step_a(arm, s, 3'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step_a(arm, s, 3'd5, 1'b0, 1'b0, 1'b0);
    step_a(arm, s, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full shot on B from IDLE up to and including the fire edge.
  task automatic to_fire_b();
    for (int i = 0; i < 3; i++) step_b(5'b11111, 3'd1, 1'b0);
    step_b(5'b00001, 3'd2, 1'b0);
    step_b(5'b00100, 3'd3, 1'b0);
    step_b(5'b10000, 3'd3, 1'b0);
    step_b(5'b10000, 3'd3, 1'b0);
    step_b(5'b10000, 3'd4, 1'b1);
    if (exp_cnt_b < 255) exp_cnt_b++;
  endtask

  task automatic shot_b();
    to_fire_b();
    for (int i = 0; i < 3; i++) step_b(5'b00000, 3'd4, 1'b1);
    step_b(5'b00000, 3'd0, 1'b0);
  endtask

  initial begin
    rst_na = 1'b0; arm_a = 1'b0; sens_a = 3'b000;
    rst_nb = 1'b0; arm_b = 1'b0; sens_b = 5'b00000;
    #12;
    check_val("a_rst_state", 32'(st_a), 32'd0);
    check_val("a_rst_fire", 32'(fire_a), 32'd0);
    check_val("a_rst_busy", 32'(busy_a), 32'd0);
    check_val("a_rst_cnt", 32'(cnt_a), 32'd0);
    check_val("b_rst_state", 32'(st_b), 32'd0);
    check_val("b_rst_cnt", 32'(cnt_b), 32'd0);
    rst_na = 1'b1;
    rst_nb = 1'b1;

    phase = "idle";
    step_a(1'b0, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

    phase = "basic_fire";
    prefix_a();
    step_a(1'b1, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b100, 3'd4, 1'b1, 1'b0, 1'b0);
    exp_cnt_a++;
    cooldown_a(1'b1, 3'b111);
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    check_val("a_cnt", 32'(cnt_a), 32'(exp_cnt_a));

    phase = "timeout";
    prefix_a();
    for (int i = 0; i < 15; i++) step_a(1'b1, 3'b000, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

    phase = "last_cycle_fire";
    prefix_a();
    step_a(1'b1, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step_a(1'b1, 3'b000, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b100, 3'd4, 1'b1, 1'b0, 1'b0);
    exp_cnt_a++;
    cooldown_a(1'b1, 3'b000);
    check_val("a_cnt", 32'(cnt_a), 32'(exp_cnt_a));

    phase = "abort";
    prefix_a();
    step_a(1'b1, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b101, 3'd0, 1'b0, 1'b1, 1'b0);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    prefix_a();
    step_a(1'b1, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b100, 3'd4, 1'b1, 1'b0, 1'b0);
    exp_cnt_a++;
    cooldown_a(1'b1, 3'b000);

    phase = "calib_fault";
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b001, 3'd2, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0);

    phase = "disarm";
    prefix_a();
    step_a(1'b1, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b0, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    check_val("a_cnt", 32'(cnt_a), 32'(exp_cnt_a));
    prefix_a();
    step_a(1'b1, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0);
    step_a(1'b1, 3'b100, 3'd4, 1'b1, 1'b0, 1'b0);
    exp_cnt_a++;
    cooldown_a(1'b0, 3'b111);
    check_val("a_cnt", 32'(cnt_a), 32'(exp_cnt_a));

    phase = "wide_params";
    shot_b();
    check_val("b_cnt", 32'(cnt_b), 32'(exp_cnt_b));
    for (int n = 0; n < 255; n++) shot_b();
    check_val("b_cnt_sat", 32'(cnt_b), 32'd255);
    check_val("b_cnt_model", 32'(cnt_b), 32'(exp_cnt_b));

    phase = "reset_mid_fire";
    to_fire_b();
    step_b(5'b00000, 3'd4, 1'b1);
    #2;
    rst_nb = 1'b0;
    #1;
    check_val("b_rst_fire", 32'(fire_b), 32'd0);
    check_val("b_rst_state", 32'(st_b), 32'd0);
    check_val("b_rst_busy", 32'(busy_b), 32'd0);
    check_val("b_rst_cnt", 32'(cnt_b), 32'd0);
    check_val("b_rst_abort", 32'(abort_b), 32'd0);
    check_val("b_rst_timeout", 32'(timeout_b), 32'd0);
    #2;
    rst_nb = 1'b1;
    exp_cnt_b = 0;
    shot_b();
    check_val("b_cnt_after_rst", 32'(cnt_b), 32'(exp_cnt_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/targeting_controller.md
Name: targeting_controller

Overview:
Parametrised next-generation proton targeting sequencer for the OBC fire-control path.
- Detects the sensor sequence: N-cycle calibration, then left gate, then centre gate.
- Then counts hit samples inside a bounded window and issues a registered fire pulse of programmable width.
- Adds features the previous generation lacks: arm enable, post-fire cooldown, abort/timeout status pulses, and a shot counter.

Parameters:
SENSOR_W, 3, sensor bus width; must be ≥3.
CALIB_CYCLES, 2, consecutive all-ones samples required; must be ≥1.
WINDOW_LEN, 16, maximum window cycles; must be ≥1.
HITS_REQ, 2, hit samples needed to fire; must be ≥1.
FIRE_LEN, 1, proton_fire pulse width in cycles; must be ≥1.
COOLDOWN, 8, lockout cycles after the fire pulse; 0 means no lockout.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
arm_en  in  1  system armed; low forces disarm (see Behaviour).
sensor_in  in  SENSOR_W  sensor sample, one per cycle.
proton_fire  out  1  fire command, registered.
abort_o  out  1  1-cycle pulse when the window is killed by the ABORT pattern.
timeout_o  out  1  1-cycle pulse when the window expires without firing.
busy  out  1  high whenever state is not IDLE (registered state decode).
state_o  out  3  current state encoding.
fire_count  out  8  saturating shot counter.

Behaviour:
- Reset: rst_n is asynchronous, active-low. clk is the clock. On reset:
  - state = IDLE.
  - All counters = 0.
  - proton_fire, abort_o, timeout_o = 0; fire_count = 0.
- Patterns:
  - CAL = all ones.
  - GL = bit0 only.
  - GC = bit (SENSOR_W/2) only.
  - HIT = bit (SENSOR_W-1) only.
  - ABORT = HIT | bit0.
  - For W=3 these are 111, 001, 010, 100, 101.
- Default each cycle: abort_o = 0, timeout_o = 0.
- State encoding: IDLE=0, CALIB=1, GATE_LEFT=2, WINDOW=3, FIRE=4, COOLDOWN=5.
- Disarm: arm_en = 0 in IDLE, CALIB, GATE_LEFT or WINDOW → IDLE next cycle. No status pulse, counters cleared. FIRE and COOLDOWN ignore arm_en.
- IDLE: arm_en & CAL → CALIB with cal_cnt = 1; otherwise stay.
- CALIB:
  - If cal_cnt < CALIB_CYCLES: CAL → cal_cnt+1; anything else → IDLE.
  - If cal_cnt == CALIB_CYCLES: GL → GATE_LEFT; anything else → IDLE. Extra CAL samples also go to IDLE.
- GATE_LEFT: GC → WINDOW with cycle = 1, hits = 0; anything else → IDLE.
- WINDOW, checked in priority order:
  - ABORT → IDLE, abort_o = 1.
  - HIT with hits == HITS_REQ-1 → FIRE; proton_fire = 1 on the same edge; fire_count + 1, saturating at 255.
  - HIT otherwise → hits+1. Then, if cycle == WINDOW_LEN → IDLE with timeout_o = 1; else cycle+1.
  - Any other value: cycle == WINDOW_LEN → IDLE with timeout_o = 1; else cycle+1.
  - Hits need not be consecutive. A hit on the last window cycle still fires if it completes the count.
- Fire latency: proton_fire is high from the edge that samples the final HIT, for exactly FIRE_LEN cycles. A fire_cnt counter tracks the pulse in FIRE.
- FIRE: when the pulse completes, proton_fire = 0. Next state is COOLDOWN with cd_cnt = 1, or IDLE if COOLDOWN == 0.
- COOLDOWN: sensors ignored. → IDLE when cd_cnt == COOLDOWN, else cd_cnt+1.
- Back-to-back fires: the earliest re-entry to CALIB is the cycle after returning to IDLE.
- Counter widths:
  - cycle: $clog2(WINDOW_LEN+1).
  - hits: $clog2(HITS_REQ+1).
  - cal_cnt, fire_cnt, cd_cnt: sized to their parameter likewise.
  - Counters never wrap within a state.
- Reset mid-pulse: proton_fire drops immediately (asynchronously). fire_count is cleared.

Decomposition:
- targeting_pkg contains:
  - state enum (3-bit).
  - pattern functions cal_pat / gl_pat / gc_pat / hit_pat / abort_pat(SENSOR_W).
  - default parameter constants.
- One sub-module, targeting_window_ctr, owns the cycle and hit counters:
  - Inputs: start, step, hit.
  - Outputs: last_cycle, hits_done.
  - Parameters: WINDOW_LEN, HITS_REQ.
- FSM, fire/cooldown timers and fire_count stay in the top.

Test Plan:
1. Defaults, arm_en=1, sequence 111, 111, 001, 010, 100, 000, 100 → proton_fire high exactly 1 cycle, from the edge sampling the second 100. state_o goes 4 then 5 for 8 cycles, then 0. fire_count = 1.
2. Same prefix, window of 000 for 16 samples → timeout_o pulse on the 16th window sample, state_o = 0, no fire. Then a 100 on window cycle 16 after one earlier hit → fires.
3. Window hit 100, then 101 → abort_o 1-cycle pulse, IDLE, no fire, hits cleared on re-entry.
4. Calibration faults: 111, 001 → IDLE. 111, 111, 111 → IDLE. 111, 111, 001, 001 → IDLE.
5. arm_en dropped mid-WINDOW → IDLE next cycle with no pulses. arm_en dropped during COOLDOWN → cooldown still completes. Sequence presented during COOLDOWN → ignored.
6. Params SENSOR_W=5, CALIB_CYCLES=3, HITS_REQ=3, FIRE_LEN=4, COOLDOWN=0: 11111×3, 00001, 00100, 10000×3 → proton_fire high 4 cycles, then IDLE. Also run 256 shots → fire_count saturates at 255. rst_n asserted mid-fire → all outputs 0 immediately.
